// File: rtl/multi_cycle_control.sv
// multi_cycle_control
//   Moore controller for a multi-cycle RV32 subset datapath: lw, sw, R-type,
//   I-type ALU, beq and jal. Any other opcode is dropped in DECODE.
//   One state per clock, with no stalls.
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   op, f3, f7        : opcode, funct3, funct7[5] from the instruction register
//   zero              : ALU zero flag (used only for the beq PC write)
//   pcWrite, adrSrc, memWrite, irWrite, resSrc, ALUcontrol,
//   aluSrcA, aluSrcB, inmSrc, regWrite : datapath controls
//   state             : current state, for debug
module multi_cycle_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] op,
   input  logic [2:0] f3,
   input  logic       f7,
   input  logic       zero,
   output logic       pcWrite,
   output logic       adrSrc,
   output logic       memWrite,
   output logic       irWrite,
   output logic [1:0] resSrc,
   output logic [2:0] ALUcontrol,
   output logic [1:0] aluSrcA,
   output logic [1:0] aluSrcB,
   output logic [1:0] inmSrc,
   output logic       regWrite,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10
   } state_t;

   state_t     st, nx;
   logic       pc_update, branch, ir_write, mem_write, reg_write;
   logic [1:0] alu_op;

   always_ff @(posedge clk) begin
      if (rst) st <= FETCH;
      else     st <= nx;
   end

   always_comb begin
      nx = FETCH;
      case (st)
         FETCH:   nx = DECODE;
         DECODE:
            case (op)
               7'b0000011, 7'b0100011: nx = MEMADR;
               7'b0110011:             nx = EXECR;
               7'b0010011:             nx = EXECI;
               7'b1100011:             nx = BEQ;
               7'b1101111:             nx = JAL;
               default:                nx = FETCH;
            endcase
         MEMADR:  nx = op[5] ? MEMWRITE : MEMREAD;
         MEMREAD: nx = MEMWB;
         EXECR:   nx = ALUWB;
         EXECI:   nx = ALUWB;
         // jal writes rd = OldPC+4 (latched in ALUOut during JAL) in ALUWB,
         // giving the 4-cycle 0,1,10,8 sequence.
         JAL:     nx = ALUWB;
         default: nx = FETCH;
      endcase
   end

   always_comb begin
      pc_update = 1'b0;
      branch    = 1'b0;
      ir_write  = 1'b0;
      mem_write = 1'b0;
      reg_write = 1'b0;
      adrSrc    = 1'b0;
      resSrc    = 2'b00;
      aluSrcA   = 2'b00;
      aluSrcB   = 2'b00;
      alu_op    = 2'b00;
      case (st)
         FETCH: begin
            ir_write  = 1'b1;
            aluSrcB   = 2'b10;
            resSrc    = 2'b10;
            pc_update = 1'b1;
         end
         DECODE: begin
            aluSrcA = 2'b01;
            aluSrcB = 2'b01;
         end
         MEMADR: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
         end
         MEMREAD:  adrSrc = 1'b1;
         MEMWB: begin
            resSrc    = 2'b01;
            reg_write = 1'b1;
         end
         MEMWRITE: begin
            adrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         EXECR: begin
            aluSrcA = 2'b10;
            alu_op  = 2'b10;
         end
         EXECI: begin
            aluSrcA = 2'b10;
            aluSrcB = 2'b01;
            alu_op  = 2'b10;
         end
         ALUWB:    reg_write = 1'b1;
         BEQ: begin
            aluSrcA = 2'b10;
            alu_op  = 2'b01;
            branch  = 1'b1;
         end
         JAL: begin
            aluSrcA   = 2'b01;
            aluSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         default: ;
      endcase
   end

   // Immediate format follows the opcode in every state so it is ready in DECODE.
   always_comb begin
      case (op)
         7'b0100011: inmSrc = 2'b01;
         7'b1100011: inmSrc = 2'b10;
         7'b1101111: inmSrc = 2'b11;
         default:    inmSrc = 2'b00;
      endcase
   end

   always_comb begin
      ALUcontrol = 3'b000;
      case (alu_op)
         2'b01: ALUcontrol = 3'b001;
         2'b10:
            case (f3)
               // sub only for R-type (op[5]=1); addi ignores funct7.
               3'b000:  ALUcontrol = (op[5] & f7) ? 3'b001 : 3'b000;
               3'b010:  ALUcontrol = 3'b101;
               3'b110:  ALUcontrol = 3'b011;
               3'b111:  ALUcontrol = 3'b010;
               default: ALUcontrol = 3'b000;
            endcase
         default: ALUcontrol = 3'b000;
      endcase
   end

   // Write enables are held off while reset is asserted; zero reaches
   // pcWrite combinationally only through the branch term.
   assign pcWrite  = ~rst & (pc_update | (branch & zero));
   assign irWrite  = ~rst & ir_write;
   assign memWrite = ~rst & mem_write;
   assign regWrite = ~rst & reg_write;
   assign state    = st;

endmodule

// File: tb/tb_multi_cycle_control.sv
module tb_multi_cycle_control;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] op = 7'd0;
   logic [2:0] f3 = 3'd0;
   logic       f7 = 1'b0;
   logic       zero = 1'b0;
   logic       pcWrite, adrSrc, memWrite, irWrite, regWrite;
   logic [1:0] resSrc, aluSrcA, aluSrcB, inmSrc;
   logic [2:0] ALUcontrol;
   logic [3:0] state;

   multi_cycle_control dut (
      .clk(clk), .rst(rst), .op(op), .f3(f3), .f7(f7), .zero(zero),
      .pcWrite(pcWrite), .adrSrc(adrSrc), .memWrite(memWrite), .irWrite(irWrite),
      .resSrc(resSrc), .ALUcontrol(ALUcontrol), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
      .inmSrc(inmSrc), .regWrite(regWrite), .state(state)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                          IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                          IL = 7'b1111111;

   typedef struct {
      logic       rst;
      logic [6:0] op;
      logic [2:0] f3;
      logic       f7, z;
      logic [3:0] st;
      logic       pcw, adr, mw, irw;
      logic [1:0] res;
      logic [2:0] aluc;
      logic [1:0] sa, sb, imm;
      logic       rw;
   } vec_t;

   vec_t tv[$];
   int   pass_cnt = 0;
   int   total    = 0;

   function automatic vec_t v(logic r, logic [6:0] o, logic [2:0] ff3, logic ff7, logic zz,
                              logic [3:0] s, logic pcw, logic adr, logic mw, logic irw,
                              logic [1:0] res, logic [2:0] aluc, logic [1:0] sa,
                              logic [1:0] sb, logic [1:0] imm, logic rw);
      vec_t t;
      t.rst = r; t.op = o; t.f3 = ff3; t.f7 = ff7; t.z = zz;
      t.st = s; t.pcw = pcw; t.adr = adr; t.mw = mw; t.irw = irw;
      t.res = res; t.aluc = aluc; t.sa = sa; t.sb = sb; t.imm = imm; t.rw = rw;
      return t;
   endfunction

   function automatic logic [19:0] pack_exp(vec_t t);
      return {t.st, t.pcw, t.adr, t.mw, t.irw, t.res, t.aluc, t.sa, t.sb, t.imm, t.rw};
   endfunction

   function automatic logic [19:0] pack_got();
      return {state, pcWrite, adrSrc, memWrite, irWrite, resSrc, ALUcontrol,
              aluSrcA, aluSrcB, inmSrc, regWrite};
   endfunction

   task automatic check(string name, logic [19:0] got, logic [19:0] exp);
      total++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %05h expected %05h (st,pcw,adr,mw,irw,res,aluc,sa,sb,imm,rw)",
                    name, got, exp);
   endtask

   task automatic check1(string name, logic got, logic exp);
      total++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %b expected %b", name, got, exp);
   endtask

   initial begin
      //                rst op f3 f7 z   st pcw adr mw irw res aluc sa sb imm rw
      // lw behind reset: reset row keeps FETCH but write enables low
      tv.push_back(v(1, LW, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1));
      // sw
      tv.push_back(v(0, SW, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 1, 0));
      tv.push_back(v(0, SW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tv.push_back(v(0, SW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
      tv.push_back(v(0, SW, 0, 0, 0,   5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0));
      // R-type sub
      tv.push_back(v(0, RT, 0, 1, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, RT, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, RT, 0, 1, 0,   6, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0));
      tv.push_back(v(0, RT, 0, 1, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // R-type add (f7=0)
      tv.push_back(v(0, RT, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, RT, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, RT, 0, 0, 0,   6, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
      tv.push_back(v(0, RT, 0, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // R-type slt
      tv.push_back(v(0, RT, 2, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, RT, 2, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, RT, 2, 0, 0,   6, 0, 0, 0, 0, 0, 5, 2, 0, 0, 0));
      tv.push_back(v(0, RT, 2, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // R-type or
      tv.push_back(v(0, RT, 6, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, RT, 6, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, RT, 6, 0, 0,   6, 0, 0, 0, 0, 0, 3, 2, 0, 0, 0));
      tv.push_back(v(0, RT, 6, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // addi with f7=1: stays add because op[5]=0
      tv.push_back(v(0, IT, 0, 1, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, IT, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, IT, 0, 1, 0,   7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      tv.push_back(v(0, IT, 0, 1, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // andi
      tv.push_back(v(0, IT, 7, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, IT, 7, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, IT, 7, 0, 0,   7, 0, 0, 0, 0, 0, 2, 2, 1, 0, 0));
      tv.push_back(v(0, IT, 7, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      // beq not taken; zero=1 outside BEQ must not add a PC write in DECODE
      tv.push_back(v(0, BQ, 0, 0, 1,   0, 1, 0, 0, 1, 2, 0, 0, 2, 2, 0));
      tv.push_back(v(0, BQ, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
      tv.push_back(v(0, BQ, 0, 0, 0,   9, 0, 0, 0, 0, 0, 1, 2, 0, 2, 0));
      // beq taken
      tv.push_back(v(0, BQ, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 2, 0));
      tv.push_back(v(0, BQ, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0));
      tv.push_back(v(0, BQ, 0, 0, 1,   9, 1, 0, 0, 0, 0, 1, 2, 0, 2, 0));
      // jal
      tv.push_back(v(0, JL, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 3, 0));
      tv.push_back(v(0, JL, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0));
      tv.push_back(v(0, JL, 0, 0, 0,  10, 1, 0, 0, 0, 0, 0, 1, 2, 3, 0));
      tv.push_back(v(0, JL, 0, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0, 0, 3, 1));
      // illegal op dropped after DECODE
      tv.push_back(v(0, IL, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, IL, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      // lw, reset asserted in MEMREAD
      tv.push_back(v(0, LW, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      tv.push_back(v(1, LW, 0, 0, 0,   3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(v(1, LW, 0, 0, 0,   0, 0, 0, 0, 0, 2, 0, 0, 2, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 0, 0));
      // lw, reset asserted in MEMWB masks regWrite
      tv.push_back(v(0, LW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0));
      tv.push_back(v(0, LW, 0, 0, 0,   3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      tv.push_back(v(1, LW, 0, 0, 0,   4, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      tv.push_back(v(0, SW, 0, 0, 0,   0, 1, 0, 0, 1, 2, 0, 0, 2, 1, 0));
      // sw, reset asserted in MEMWRITE masks memWrite
      tv.push_back(v(0, SW, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0));
      tv.push_back(v(0, SW, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0));
      tv.push_back(v(1, SW, 0, 0, 0,   5, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));

      rst = 1'b1;
      repeat (2) @(posedge clk);

      foreach (tv[i]) begin
         @(negedge clk);
         rst = tv[i].rst; op = tv[i].op; f3 = tv[i].f3; f7 = tv[i].f7; zero = tv[i].z;
         #1;
         check($sformatf("row%0d", i), pack_got(), pack_exp(tv[i]));
         @(posedge clk);
      end

      // beq: zero toggled within one BEQ cycle drives pcWrite combinationally
      @(negedge clk);
      rst = 1'b0; op = BQ; f3 = 3'd0; f7 = 1'b0; zero = 1'b0;
      #1 check1("beq_start_fetch", state == 4'd0, 1'b1);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      check1("beq_in_beq", state == 4'd9, 1'b1);
      zero = 1'b1; #1 check1("beq_z1", pcWrite, 1'b1);
      zero = 1'b0; #1 check1("beq_z0", pcWrite, 1'b0);
      zero = 1'b1; #1 check1("beq_z1_again", pcWrite, 1'b1);
      @(posedge clk);
      #1 check1("beq_next_fetch", state == 4'd0, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
